// File: rtl/accu_core_pkg.sv
// accu_core_pkg: opcode constants, FSM state type and opcode class helpers for accu_core.
package accu_core_pkg;
    typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_e;
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_LDA  = 4'h2;
    localparam logic [3:0] OP_STA  = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_ADD  = 4'h5;
    localparam logic [3:0] OP_SUBI = 4'h6;
    localparam logic [3:0] OP_SUB  = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_BRZ  = 4'h9;
    localparam logic [3:0] OP_BRC  = 4'hA;
    localparam logic [3:0] OP_BRN  = 4'hB;
    localparam logic [3:0] OP_ADC  = 4'hC;
    localparam logic [3:0] OP_AND  = 4'hD;
    localparam logic [3:0] OP_RSV  = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;
    function automatic logic is_mem_op(input logic [3:0] op);
        return op inside {OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_ADC, OP_AND};
    endfunction
    function automatic logic is_imm_op(input logic [3:0] op);
        return op inside {OP_LDI, OP_ADDI, OP_SUBI};
    endfunction
endpackage

// File: rtl/accu_core_scan.sv
// accu_core_scan: parallel-load snapshot register shifted out MSB-first on scan_clk_i.
module accu_core_scan #(
    parameter int W = 32
) (
    input  logic         scan_clk_i,
    input  logic         scan_en_i,
    input  logic [W-1:0] snap_i,
    output logic         scan_o
);
    logic [W-1:0] sh_q;
    always_ff @(posedge scan_clk_i)
        sh_q <= scan_en_i ? {sh_q[W-2:0], 1'b0} : snap_i;
    assign scan_o = sh_q[W-1];
endmodule

// File: rtl/accu_core.sv
// accu_core: multicycle accumulator CPU with a single req/ack memory port.
// Define ACCU_CORE_SCAN_EN to build the scan snapshot chain; otherwise scan_out is tied 0.
module accu_core
    import accu_core_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 8,
    parameter int RW = (4 + AW > DW) ? 4 + AW : DW
) (
    input  logic          clk,
    input  logic          rst,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [RW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          halted,
    input  logic          scan_clk,
    input  logic          scan_en,
    output logic          scan_out
);
    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d, opnd_q, opnd_d;
    logic [3:0]    op_q, op_d;
    logic [DW-1:0] acc_q, acc_d, b, res;
    logic          c_q, c_d, z_q, z_d, n_q, n_d;
    logic [DW:0]   sum, dif;
    logic          cout, wr, taken, ld, sub;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= '0;
            opnd_q  <= '0;
            op_q    <= '0;
            acc_q   <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            opnd_q  <= opnd_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
            z_q     <= z_d;
            n_q     <= n_d;
        end
    end
    // One ALU serves both the immediate (EXEC) and memory (MEM) forms of each op.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        opnd_d  = opnd_q;
        op_d    = op_q;
        acc_d   = acc_q;
        c_d     = c_q;
        z_d     = z_q;
        n_d     = n_q;
        wr      = 1'b0;
        b       = (state_q == MEM) ? mem_rdata[DW-1:0] : DW'(opnd_q);
        sum     = {1'b0, acc_q} + {1'b0, b} + (DW+1)'(op_q == OP_ADC && c_q);
        dif     = {1'b0, acc_q} - {1'b0, b};
        ld      = op_q == OP_LDI || op_q == OP_LDA;
        sub     = op_q == OP_SUBI || op_q == OP_SUB;
        res     = ld ? b : sub ? dif[DW-1:0] : (op_q == OP_AND) ? (acc_q & b) : sum[DW-1:0];
        cout    = ld ? 1'b0 : sub ? dif[DW] : (op_q == OP_AND) ? c_q : sum[DW];
        taken   = (op_q == OP_BRZ && z_q) || (op_q == OP_BRC && c_q) || (op_q == OP_BRN && n_q);
        case (state_q)
            FETCH: if (mem_ack) begin
                op_d    = mem_rdata[AW+3:AW];
                opnd_d  = mem_rdata[AW-1:0];
                state_d = EXEC;
            end
            EXEC: begin
                state_d = is_mem_op(op_q) ? MEM : (op_q == OP_HLT) ? HALT : FETCH;
                wr      = is_imm_op(op_q);
                pc_d    = (op_q == OP_JMP) ? opnd_q :
                          taken ? pc_q + opnd_q :
                          (is_mem_op(op_q) || op_q == OP_HLT) ? pc_q : pc_q + 1'b1;
            end
            MEM: if (mem_ack) begin
                state_d = FETCH;
                pc_d    = pc_q + 1'b1;
                wr      = op_q != OP_STA;
            end
            default: ;
        endcase
        if (wr) begin
            acc_d = res;
            c_d   = cout;
            z_d   = res == '0;
            n_d   = res[DW-1];
        end
    end
    assign mem_req   = !rst && (state_q == FETCH || state_q == MEM);
    assign mem_we    = state_q == MEM && op_q == OP_STA;
    assign mem_addr  = (state_q == MEM) ? opnd_q : pc_q;
    assign mem_wdata = acc_q;
    assign halted    = state_q == HALT;
`ifdef ACCU_CORE_SCAN_EN
    accu_core_scan #(.W(4 + AW + DW + 3 + AW + 2)) u_scan (
        .scan_clk_i (scan_clk),
        .scan_en_i  (scan_en),
        .snap_i     ({op_q, opnd_q, acc_q, c_q, z_q, n_q, pc_q, state_q}),
        .scan_o     (scan_out)
    );
`else
    logic unused_scan;
    assign unused_scan = scan_clk ^ scan_en;
    assign scan_out    = 1'b0;
`endif
endmodule
